// File: rtl/hb_wb_gateway_pkg.sv
// Types and helpers shared by the hostbus-to-Wishbone gateway files.
package hb_wb_gateway_pkg;
`include "hb_wb_defs.vh"

  typedef enum logic [1:0] {
    ST_IDLE = `HB_ST_IDLE,
    ST_BUS  = `HB_ST_BUS,
    ST_DONE = `HB_ST_DONE
  } hb_state_e;

  // Bit positions of the strobes inside the synchronizer vector.
  localparam int SYNC_CS = 2;
  localparam int SYNC_OE = 1;
  localparam int SYNC_WE = 0;

  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction
endpackage

// File: rtl/hb_wb_gateway_if.sv
// Wishbone master/slave signal bundle used by the gateway.
interface hb_wb_gateway_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              wb_cycle;
  logic              wb_strobe;
  logic              wb_write;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_wrData;
  logic [DATA_W-1:0] wb_rdData;
  logic              wb_ack;
  logic              wb_err;

  modport master (
    output wb_cycle, wb_strobe, wb_write, wb_addr, wb_wrData,
    input  wb_rdData, wb_ack, wb_err
  );
  modport slave (
    input  wb_cycle, wb_strobe, wb_write, wb_addr, wb_wrData,
    output wb_rdData, wb_ack, wb_err
  );
endinterface

// File: rtl/hb_wb_defs.vh
// Shared FSM state encodings for the hostbus-to-Wishbone gateway.
`ifndef HB_WB_DEFS_VH
`define HB_WB_DEFS_VH
`define HB_ST_IDLE 2'd0
`define HB_ST_BUS  2'd1
`define HB_ST_DONE 2'd2
`endif

// File: rtl/hb_wb_gateway_sync.sv
// Multi-flop synchronizer for the asynchronous hostbus strobes; resets to all ones (inactive).
module hb_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [WIDTH-1:0] stage_r [N];

  // Shift chain; stage 0 is the only flop that sees the raw pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) stage_r[i] <= '1;
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < N; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  assign dout = stage_r[N-1];
endmodule

// File: rtl/hb_wb_gateway.sv
// Bridges an asynchronous active-low hostbus onto a synchronous Wishbone master port.
module hb_wb_gateway
  import hb_wb_gateway_pkg::*;
#(
  parameter int              ADDR_W      = 16,
  parameter int              DATA_W      = 16,
  parameter int              SYNC_STAGES = 2,
  parameter int              TIMEOUT_CYC = 255,
  parameter logic [DATA_W-1:0] ERR_DATA  = 16'hDEAD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hb_cs,
  input  logic              hb_oe,
  input  logic              hb_we,
  input  logic [ADDR_W-1:0] hb_addr,
  inout  wire  [DATA_W-1:0] hb_data,
  output logic              hb_rdy,
  output logic              hb_err,
  hb_wb_gateway_if.master   wb
);
  localparam int              CNT_W     = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  logic [2:0]        sync_s;
  logic              cs_s, oe_s, we_s, timeout_s;
  hb_state_e         state_r, next_state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_d;
  logic              cycle_r, cycle_d, write_r, write_d;
  logic              rdy_r, rdy_d, err_r, err_d, rd_valid_r, rd_valid_d;
  logic [ADDR_W-1:0] addr_r, addr_d;
  logic [DATA_W-1:0] wrdata_r, wrdata_d, rdlatch_r, rdlatch_d;

  hb_sync #(.WIDTH(3), .STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  ({hb_cs, hb_oe, hb_we}),
    .dout (sync_s)
  );

  assign cs_s      = sync_s[SYNC_CS];
  assign oe_s      = sync_s[SYNC_OE];
  assign we_s      = sync_s[SYNC_WE];
  assign timeout_s = (TIMEOUT_CYC != 0) && (cnt_r == CNT_LIMIT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= next_state_s;
  end

  // Next-state decode; IDLE is only re-entered with cs high, so strobe toggles under a held cs are ignored.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!cs_s && (oe_s ^ we_s))      next_state_s = ST_BUS;
        else if (!cs_s && !oe_s && !we_s) next_state_s = ST_DONE;
        else                              next_state_s = ST_IDLE;
      end
      ST_BUS: begin
        if (wb.wb_err || wb.wb_ack || timeout_s) next_state_s = ST_DONE;
        else                                     next_state_s = ST_BUS;
      end
      ST_DONE: begin
        if (cs_s) next_state_s = ST_IDLE;
        else      next_state_s = ST_DONE;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Next values of all registered outputs, decided on the transition being taken.
  always_comb begin
    cnt_d      = cnt_r;
    cycle_d    = cycle_r;
    write_d    = write_r;
    addr_d     = addr_r;
    wrdata_d   = wrdata_r;
    rdy_d      = rdy_r;
    err_d      = err_r;
    rdlatch_d  = rdlatch_r;
    rd_valid_d = rd_valid_r;
    case (state_r)
      ST_IDLE: begin
        if (next_state_s == ST_BUS) begin
          cycle_d  = 1'b1;
          write_d  = ~we_s;
          addr_d   = hb_addr;
          wrdata_d = hb_data;
          cnt_d    = '0;
        end else if (next_state_s == ST_DONE) begin
          rdy_d = 1'b1;
          err_d = 1'b1;
        end else begin
          cycle_d = 1'b0;
        end
      end
      ST_BUS: begin
        if (next_state_s == ST_DONE) begin
          cycle_d    = 1'b0;
          rdy_d      = 1'b1;
          rd_valid_d = ~write_r;
          // A slave error outranks a simultaneous ack.
          if (wb.wb_err || timeout_s) begin
            rdlatch_d = ERR_DATA;
            err_d     = 1'b1;
          end else begin
            rdlatch_d = wb.wb_rdData;
            err_d     = 1'b0;
          end
        end else begin
          cnt_d = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (next_state_s == ST_IDLE) begin
          rdy_d      = 1'b0;
          err_d      = 1'b0;
          rd_valid_d = 1'b0;
        end else begin
          rdy_d = 1'b1;
        end
      end
      default: begin
        cycle_d = 1'b0;
        rdy_d   = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= '0;
      cycle_r    <= 1'b0;
      write_r    <= 1'b0;
      addr_r     <= '0;
      wrdata_r   <= '0;
      rdy_r      <= 1'b0;
      err_r      <= 1'b0;
      rdlatch_r  <= '0;
      rd_valid_r <= 1'b0;
    end else begin
      cnt_r      <= cnt_d;
      cycle_r    <= cycle_d;
      write_r    <= write_d;
      addr_r     <= addr_d;
      wrdata_r   <= wrdata_d;
      rdy_r      <= rdy_d;
      err_r      <= err_d;
      rdlatch_r  <= rdlatch_d;
      rd_valid_r <= rd_valid_d;
    end
  end

  assign wb.wb_cycle  = cycle_r;
  assign wb.wb_strobe = cycle_r;
  assign wb.wb_write  = write_r;
  assign wb.wb_addr   = addr_r;
  assign wb.wb_wrData = wrdata_r;
  assign hb_rdy       = rdy_r;
  assign hb_err       = err_r;

  // Read data goes out on the raw pins so the host sees it without synchronizer delay.
  assign hb_data = (!hb_cs && !hb_oe && hb_we && (state_r == ST_DONE) && rd_valid_r)
                   ? rdlatch_r : {DATA_W{1'bz}};
endmodule

// File: tb/tb_hb_wb_gateway.sv
// Self-checking bench for hb_wb_gateway: table-driven transfers plus reset/protocol corner sequences.
module tb_hb_wb_gateway;
`include "hb_wb_defs.vh"

  localparam int SYNC = 2;
  localparam int TMO  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hb_cs = 1'b1, hb_oe = 1'b1, hb_we = 1'b1;
  logic [15:0] hb_addr = 16'h0000;
  wire  [15:0] hb_data;
  logic        hb_rdy, hb_err;
  logic        drv_en = 1'b0;
  logic [15:0] drv_val = 16'h0000;

  assign hb_data = drv_en ? drv_val : 16'hzzzz;

  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup pu (hb_data[g]);
  end

  hb_wb_gateway_if #(.ADDR_W(16), .DATA_W(16)) wbi ();

  hb_wb_gateway #(
    .ADDR_W(16), .DATA_W(16), .SYNC_STAGES(SYNC), .TIMEOUT_CYC(TMO), .ERR_DATA(16'hDEAD)
  ) dut (
    .clk(clk), .rst(rst), .hb_cs(hb_cs), .hb_oe(hb_oe), .hb_we(hb_we),
    .hb_addr(hb_addr), .hb_data(hb_data), .hb_rdy(hb_rdy), .hb_err(hb_err), .wb(wbi)
  );

  always #5 clk = ~clk;

  // mode: 0 ack, 1 wb_err, 2 ack+err together, 3 no response (timeout)
  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          dly;
    int          mode;
    logic        exp_err;
    logic [15:0] exp_data;
    int          exp_strobes;
  } vec_t;

  typedef struct {
    logic        err;
    logic [15:0] data;
    logic        rd;
  } exp_t;

  vec_t vecs [7];
  exp_t sbq [$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_underflow: got empty queue want entry");
    end else begin
      e = sbq.pop_front();
      check("hb_err", hb_err, e.err);
      if (e.rd) check("hb_data_rd", hb_data, e.data);
    end
  endtask

  task automatic wait_strobe(output int cycles);
    logic seen = 1'b0;
    cycles = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      cycles++;
      seen = wbi.wb_strobe;
    end
  endtask

  task automatic release_bus();
    hb_oe = 1'b1;
    hb_we = 1'b1;
    hb_cs = 1'b1;
    for (int k = 0; k < 10 && hb_rdy; k++) tick();
    check("rdy_clear", hb_rdy, 1'b0);
    check("err_clear", hb_err, 1'b0);
    tick();
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   n, lat, extra;
    e.err = v.exp_err;
    e.data = v.exp_data;
    e.rd = !v.wr;
    sbq.push_back(e);
    hb_addr = v.addr;
    wbi.wb_rdData = v.rdata;
    if (v.wr) begin
      drv_en  = 1'b1;
      drv_val = v.wdata;
      hb_we   = 1'b0;
    end else begin
      hb_oe = 1'b0;
    end
    hb_cs = 1'b0;
    wait_strobe(lat);
    check("strobe_latency", lat, SYNC + 1);
    check("wb_addr", wbi.wb_addr, v.addr);
    check("wb_write", wbi.wb_write, v.wr);
    if (v.wr) check("wb_wrData", wbi.wb_wrData, v.wdata);
    n = 1;
    for (int k = 0; k < 40; k++) begin
      if (v.mode != 3 && k == v.dly) begin
        wbi.wb_ack = (v.mode != 1);
        wbi.wb_err = (v.mode != 0);
      end
      tick();
      wbi.wb_ack = 1'b0;
      wbi.wb_err = 1'b0;
      if (!wbi.wb_strobe) break;
      n++;
    end
    check("strobe_clocks", n, v.exp_strobes);
    check("hb_rdy", hb_rdy, 1'b1);
    pop_compare();
    extra = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (wbi.wb_cycle) extra++;
    end
    check("no_second_cycle", extra, 0);
    if (v.wr) begin
      drv_en = 1'b0;
      #1;
      check("hb_data_undriven_wr", hb_data, 16'hFFFF);
    end else begin
      hb_oe = 1'b1;
      #1;
      check("hb_data_released_rd", hb_data, 16'hFFFF);
    end
    release_bus();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int lat, cnt;
    vecs[0] = '{1'b0, 16'h0003, 16'h0000, 16'hAAAA, 2, 0, 1'b0, 16'hAAAA, 3};
    vecs[1] = '{1'b1, 16'h0003, 16'hF0F0, 16'h0000, 2, 0, 1'b0, 16'h0000, 3};
    vecs[2] = '{1'b0, 16'h1234, 16'h0000, 16'h5A5A, 0, 0, 1'b0, 16'h5A5A, 1};
    vecs[3] = '{1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 1'b1, 16'h0000, 2};
    vecs[4] = '{1'b1, 16'h0003, 16'hF0F0, 16'h0000, 1, 2, 1'b1, 16'h0000, 2};
    vecs[5] = '{1'b0, 16'h0007, 16'h0000, 16'h1111, 3, 1, 1'b1, 16'hDEAD, 4};
    vecs[6] = '{1'b0, 16'h0009, 16'h0000, 16'h2222, 0, 3, 1'b1, 16'hDEAD, TMO};
    $display("state encodings idle=%0d bus=%0d done=%0d", `HB_ST_IDLE, `HB_ST_BUS, `HB_ST_DONE);
    wbi.wb_ack = 1'b0;
    wbi.wb_err = 1'b0;
    wbi.wb_rdData = 16'h0000;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_cycle", wbi.wb_cycle, 1'b0);
    check("rst_strobe", wbi.wb_strobe, 1'b0);
    check("rst_write", wbi.wb_write, 1'b0);
    check("rst_addr", wbi.wb_addr, 16'h0000);
    check("rst_wrdata", wbi.wb_wrData, 16'h0000);
    check("rst_rdy", hb_rdy, 1'b0);
    check("rst_err", hb_err, 1'b0);
    check("rst_hb_data", hb_data, 16'hFFFF);
    rst = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // oe and we low together: protocol error, no Wishbone cycle
    sbq.push_back('{1'b1, 16'h0000, 1'b0});
    hb_cs = 1'b0;
    hb_oe = 1'b0;
    hb_we = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10 && !hb_rdy; k++) begin
      tick();
      if (wbi.wb_cycle) cnt++;
    end
    check("proto_rdy", hb_rdy, 1'b1);
    pop_compare();
    tick();
    if (wbi.wb_cycle) cnt++;
    check("proto_no_cycle", cnt, 0);
    release_bus();

    // oe toggling under a held cs must not start another cycle
    hb_addr = 16'h0005;
    wbi.wb_rdData = 16'h3C3C;
    hb_cs = 1'b0;
    hb_oe = 1'b0;
    wait_strobe(lat);
    check("toggle_latency", lat, SYNC + 1);
    wbi.wb_ack = 1'b1;
    tick();
    wbi.wb_ack = 1'b0;
    check("toggle_rdy", hb_rdy, 1'b1);
    check("toggle_data", hb_data, 16'h3C3C);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      hb_oe = 1'b1;
      tick();
      if (wbi.wb_cycle) cnt++;
      hb_oe = 1'b0;
      tick();
      if (wbi.wb_cycle) cnt++;
    end
    check("toggle_no_cycle", cnt, 0);
    check("toggle_rdy_held", hb_rdy, 1'b1);
    check("toggle_data_again", hb_data, 16'h3C3C);
    release_bus();

    // Reset pulsed mid-BUS, with a late ack that must be ignored
    hb_addr = 16'h0006;
    hb_cs = 1'b0;
    hb_oe = 1'b0;
    wait_strobe(lat);
    check("rstbus_strobe_seen", wbi.wb_strobe, 1'b1);
    rst = 1'b1;
    hb_cs = 1'b1;
    hb_oe = 1'b1;
    wbi.wb_ack = 1'b1;
    tick();
    check("rstbus_cycle", wbi.wb_cycle, 1'b0);
    check("rstbus_strobe", wbi.wb_strobe, 1'b0);
    check("rstbus_addr", wbi.wb_addr, 16'h0000);
    rst = 1'b0;
    wbi.wb_ack = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (hb_rdy || wbi.wb_cycle) cnt++;
    end
    check("rstbus_no_completion", cnt, 0);

    check("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hb_wb_gateway.md
HB_WB_GATEWAY -- requirements
Module: hb_wb_gateway

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, width of the hostbus and Wishbone address.
REQ-002 SHALL have parameter DATA_W, default 16, width of the hostbus and Wishbone data.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, flop count of the hostbus strobe synchronizer (minimum 2).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 255, ack-wait limit in clocks (0 disables the timeout).
REQ-005 SHALL have parameter ERR_DATA, default 16'hDEAD, returned on a failed read.
REQ-006 clk  input  1  single clock; every flop is on the rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 hb_cs  input  1  hostbus chip select, active-low, asynchronous to clk.
REQ-009 hb_oe  input  1  hostbus read strobe, active-low, asynchronous.
REQ-010 hb_we  input  1  hostbus write strobe, active-low, asynchronous.
REQ-011 hb_addr  input  ADDR_W  hostbus address; stable while hb_cs is low.
REQ-012 hb_data  inout  DATA_W  hostbus data; driven only per REQ-024.
REQ-013 hb_rdy  output  1  active-high; the transfer is complete.
REQ-014 hb_err  output  1  active-high; the completed transfer failed.
REQ-015 wb_cycle, wb_strobe, wb_write  output  1 each  Wishbone master controls.
REQ-016 wb_addr  output  ADDR_W; wb_wrData  output  DATA_W; wb_rdData  input  DATA_W.
REQ-017 wb_ack, wb_err  input  1 each  Wishbone slave termination.

Function
REQ-018 SHALL pass hb_cs, hb_oe and hb_we through SYNC_STAGES flops each before any use by the FSM.
REQ-019 SHALL implement FSM states IDLE, BUS, DONE with this transition rule: IDLE->BUS when synced cs=0 and exactly one of synced oe/we is 0.
REQ-020 In IDLE with synced cs=0, oe=0 and we=0, the FSM SHALL go to DONE with hb_err=1 and SHALL NOT start a Wishbone cycle.
REQ-021 On IDLE->BUS, SHALL latch hb_addr into wb_addr and hb_data into wb_wrData, and SHALL set wb_write=1 for a write (we low) or 0 for a read.
REQ-022 In BUS, wb_cycle and wb_strobe SHALL be 1; the first strobe is registered SYNC_STAGES+1 clocks after hb_cs falls.
REQ-023 On BUS termination, the FSM SHALL go to DONE on the same edge and clear wb_cycle and wb_strobe:
  - wb_ack=1: latch wb_rdData and set hb_err=0.
  - wb_err=1: latch ERR_DATA and set hb_err=1; wb_err wins if asserted together with wb_ack.
  - wait count reaches TIMEOUT_CYC (when nonzero): same as wb_err.
REQ-024 hb_data SHALL be driven with the latched read data only while the raw pins satisfy hb_cs=0, hb_oe=0, hb_we=1 and the state is DONE of a read; otherwise it SHALL be high-Z, combinationally.
REQ-025 In DONE, hb_rdy SHALL be 1; the FSM SHALL return to IDLE on synced cs=1 and clear hb_rdy and hb_err on that edge.
REQ-026 Strobe changes while hb_cs stays low (for example, oe toggling) SHALL NOT start a second cycle; a new transfer needs cs to go high and then low again.
REQ-027 The timeout counter SHALL clear on entry to BUS and SHALL saturate rather than wrap.

Reset
REQ-028 While rst=1, SHALL set: state IDLE; wb_cycle, wb_strobe and wb_write 0; wb_addr and wb_wrData 0; hb_rdy and hb_err 0; read latch 0; synchronizers 1 (inactive); hb_data high-Z.
REQ-029 Reset asserted in BUS SHALL drop wb_cycle and wb_strobe on the next edge, with no pending completion after release.

Structure
REQ-030 State encodings (IDLE=2'd0, BUS=2'd1, DONE=2'd2) SHALL live in a shared include file, hb_wb_defs.vh, used by RTL and bench.
REQ-031 The synchronizer SHALL be one sub-module, hb_sync (parameters WIDTH and STAGES), instantiated once with WIDTH=3.

Verification
REQ-032 Read: hb_addr=3, cs/oe low, wb_rdData=16'hAAAA, ack 2 clocks after strobe -> wb_addr=3, wb_write=0, hb_rdy=1, hb_data=16'hAAAA until oe rises.
REQ-033 Write: hb_addr=3, bench drives 16'hF0F0, cs/we low, ack -> wb_write=1, wb_wrData=16'hF0F0, hb_rdy=1, hb_data never driven by the DUT.
REQ-034 Timeout: TIMEOUT_CYC=8, read with no ack -> strobe high exactly 8 clocks, then hb_err=1 and hb_data=16'hDEAD.
REQ-035 wb_err and wb_ack in the same cycle during a write -> hb_err=1, one strobe only, hb_rdy=1.
REQ-036 Protocol and reset: oe and we low together -> no wb_cycle, hb_err=1; separately, rst pulsed mid-BUS -> wb_cycle=0 next clock, hb_rdy stays 0.
